mem_access_sequencer: RTL and testbench

Multicycle controller for data-memory instructions. Main control hands it one load or store and waits for `done`. It times the synchronous memory read latency and pulses the MDR load enable. It then drives the load-size selector and register write-back for loads, or the read-modify-write store path for sub-word stores. It sits between the main control FSM and the memory/MDR/load-size/store-size datapath.

---
 rtl/mem_access_sequencer_if.sv | 26 ++
 rtl/mem_access_sequencer.sv | 145 ++++++++++++++
 tb/tb_mem_access_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_sequencer_if.sv
// Handshake and datapath-control bundle between main control and the
// memory access sequencer.
interface mem_access_sequencer_if;
  logic       start;
  logic [2:0] op;
  logic       busy;
  logic       done;
  logic       err;
  logic       mem_wr;
  logic       mdr_load;
  logic [1:0] load_size_ctrl;
  logic [1:0] store_size_ctrl;
  logic       reg_write;

  modport master (
    output start, op,
    input  busy, done, err, mem_wr, mdr_load,
           load_size_ctrl, store_size_ctrl, reg_write
  );

  modport slave (
    input  start, op,
    output busy, done, err, mem_wr, mdr_load,
           load_size_ctrl, store_size_ctrl, reg_write
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Multicycle sequencer for load/store instructions: times the synchronous
// memory read latency, pulses the MDR load, then finishes with register
// write-back (loads) or a memory write (stores, sub-word via read-modify-write).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; op captured on acceptance
// RD_WAIT | memory read in flight, down-counter times MEM_WAIT cycles
// MDR_LD  | memory data valid, MDR captures it
// WB      | register write-back of the sized load data, done
// WR      | memory write (sw direct, sh/sb merged with MDR), done
// ERR     | illegal op reported with done+err, no side effects
module mem_access_sequencer #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_access_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    MDR_LD,
    WB,
    WR,
    ERR
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [1:0] size_dec;

  // State, wait counter and captured op registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic; the counter reaching zero ends the read wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d = bus.op;
          case (bus.op)
            3'b100: state_d = WR;
            3'b000, 3'b001, 3'b010, 3'b101, 3'b110: begin
              state_d = RD_WAIT;
              cnt_d   = WAIT_LOAD;
            end
            default: state_d = ERR;
          endcase
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = MDR_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MDR_LD:  state_d = op_q[2] ? WR : WB;
      WB:      state_d = IDLE;
      WR:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access size from the captured op; illegal size code falls back to word.
  always_comb begin
    size_dec = SZ_WORD;
    case (op_q[1:0])
      2'b00:   size_dec = SZ_WORD;
      2'b01:   size_dec = SZ_HALF;
      2'b10:   size_dec = SZ_BYTE;
      default: size_dec = SZ_WORD;
    endcase
  end

  // Moore outputs decoded from the registered state and op.
  always_comb begin
    bus.busy            = 1'b0;
    bus.done            = 1'b0;
    bus.err             = 1'b0;
    bus.mem_wr          = 1'b0;
    bus.mdr_load        = 1'b0;
    bus.reg_write       = 1'b0;
    bus.load_size_ctrl  = SZ_WORD;
    bus.store_size_ctrl = SZ_WORD;
    case (state_q)
      IDLE: ;
      RD_WAIT: begin
        bus.busy            = 1'b1;
        bus.load_size_ctrl  = size_dec;
        bus.store_size_ctrl = size_dec;
      end
      MDR_LD: begin
        bus.busy            = 1'b1;
        bus.mdr_load        = 1'b1;
        bus.load_size_ctrl  = size_dec;
        bus.store_size_ctrl = size_dec;
      end
      WB: begin
        bus.busy            = 1'b1;
        bus.done            = 1'b1;
        bus.reg_write       = 1'b1;
        bus.load_size_ctrl  = size_dec;
        bus.store_size_ctrl = size_dec;
      end
      WR: begin
        bus.busy            = 1'b1;
        bus.done            = 1'b1;
        bus.mem_wr          = 1'b1;
        bus.load_size_ctrl  = size_dec;
        bus.store_size_ctrl = size_dec;
      end
      ERR: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        bus.err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: table of ops issued back-to-back against a
// scoreboard, plus hand sequences for ignored start, reset mid-op and
// MEM_WAIT=1.
module tb_mem_access_sequencer;

  typedef struct {
    logic [2:0] op;
    int         done_rel;
    int         mdr_rel;
    bit         err;
    bit         wr;
    bit         rw;
    logic [1:0] size;
  } vec_t;

  typedef struct {
    int   edge0;
    vec_t v;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t sb_q[$];
  int   busy_cnt = 0;
  int   mdr_seen = 0;
  bit   size_bad = 1'b0;
  int   done_total = 0;
  int   last_done_abs = 0;

  mem_access_sequencer_if bus();
  mem_access_sequencer_if bus1();

  mem_access_sequencer #(.MEM_WAIT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_access_sequencer #(.MEM_WAIT(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},      int'(bus.busy), 0);
    chk({tag, "_done"},      int'(bus.done), 0);
    chk({tag, "_err"},       int'(bus.err), 0);
    chk({tag, "_mem_wr"},    int'(bus.mem_wr), 0);
    chk({tag, "_mdr_load"},  int'(bus.mdr_load), 0);
    chk({tag, "_reg_write"}, int'(bus.reg_write), 0);
    chk({tag, "_load_sz"},   int'(bus.load_size_ctrl), 2);
    chk({tag, "_store_sz"},  int'(bus.store_size_ctrl), 2);
  endtask

  // Scoreboard monitor: compares each completed operation against the front entry.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
      mdr_seen = 0;
      size_bad = 1'b0;
    end else begin
      if ((int'(bus.mem_wr) + int'(bus.mdr_load) + int'(bus.reg_write)) > 1)
        chk("enables_exclusive", 1, 0);
      if ((bus.mem_wr || bus.reg_write) && !bus.done)
        chk("write_without_done", 1, 0);
      if (bus.err && !bus.done)
        chk("err_without_done", 1, 0);
      if (bus.mdr_load) begin
        if (sb_q.size() == 0) chk("mdr_load_unexpected", 1, 0);
        else mdr_seen = cyc - sb_q[0].edge0 + 1;
      end
      if (bus.busy && sb_q.size() != 0) begin
        busy_cnt++;
        if (bus.load_size_ctrl != sb_q[0].v.size || bus.store_size_ctrl != sb_q[0].v.size)
          size_bad = 1'b1;
      end
      if (bus.done) begin
        done_total++;
        last_done_abs = cyc;
        if (sb_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk($sformatf("op%03b_done_latency", e.v.op), cyc - e.edge0 + 1, e.v.done_rel);
          chk($sformatf("op%03b_mdr_cycle", e.v.op), mdr_seen, e.v.mdr_rel);
          chk($sformatf("op%03b_err", e.v.op), int'(bus.err), int'(e.v.err));
          chk($sformatf("op%03b_mem_wr", e.v.op), int'(bus.mem_wr), int'(e.v.wr));
          chk($sformatf("op%03b_reg_write", e.v.op), int'(bus.reg_write), int'(e.v.rw));
          chk($sformatf("op%03b_busy_cycles", e.v.op), busy_cnt, e.v.done_rel);
          chk($sformatf("op%03b_size_ctrl", e.v.op), int'(size_bad), 0);
        end
        busy_cnt = 0;
        mdr_seen = 0;
        size_bad = 1'b0;
      end
    end
  end

  // Called at a negedge in an idle cycle; returns at the first negedge idle again.
  task automatic issue(input vec_t v);
    exp_t e;
    bit   idle;
    bus.start = 1'b1;
    bus.op    = v.op;
    e.edge0   = cyc + 1;
    e.v       = v;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    idle = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.busy) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) chk("idle_timeout", 0, 1);
  endtask

  vec_t vecs[10];

  initial begin
    int d_prev;
    int d_before;
    int m1, d1, rw1, sz1;
    int e1;

    vecs[0] = '{3'b000, 4, 3, 1'b0, 1'b0, 1'b1, 2'b10}; // lw
    vecs[1] = '{3'b010, 4, 3, 1'b0, 1'b0, 1'b1, 2'b00}; // lb
    vecs[2] = '{3'b001, 4, 3, 1'b0, 1'b0, 1'b1, 2'b01}; // lh
    vecs[3] = '{3'b100, 1, 0, 1'b0, 1'b1, 1'b0, 2'b10}; // sw
    vecs[4] = '{3'b110, 4, 3, 1'b0, 1'b1, 1'b0, 2'b00}; // sb
    vecs[5] = '{3'b101, 4, 3, 1'b0, 1'b1, 1'b0, 2'b01}; // sh
    vecs[6] = '{3'b011, 1, 0, 1'b1, 1'b0, 1'b0, 2'b10}; // illegal
    vecs[7] = '{3'b000, 4, 3, 1'b0, 1'b0, 1'b1, 2'b10}; // lw
    vecs[8] = '{3'b111, 1, 0, 1'b1, 1'b0, 1'b0, 2'b10}; // illegal
    vecs[9] = '{3'b100, 1, 0, 1'b0, 1'b1, 1'b0, 2'b10}; // sw

    bus.start  = 1'b0;
    bus.op     = 3'b000;
    bus1.start = 1'b0;
    bus1.op    = 3'b000;

    #12;
    chk_reset_vals("in_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("idle");

    // Table, issued back-to-back.
    d_prev = 0;
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i]);
      if (i == 2) chk("b2b_lb_lh_done_gap", last_done_abs - d_prev, 5);
      d_prev = last_done_abs;
    end
    chk("table_queue_drained", sb_q.size(), 0);

    // start during an in-flight lw is ignored.
    d_before = done_total;
    begin
      exp_t e;
      bus.start = 1'b1;
      bus.op    = 3'b000;
      e.edge0   = cyc + 1;
      e.v       = vecs[0];
      sb_q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 3'b100;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (6) @(negedge clk);
    end
    chk("ignored_start_single_done", done_total - d_before, 1);
    chk("ignored_start_busy_after", int'(bus.busy), 0);
    chk("ignored_start_queue", sb_q.size(), 0);

    // Reset in cycle 2 of an sh abandons it.
    begin
      exp_t e;
      bus.start = 1'b1;
      bus.op    = 3'b101;
      e.edge0   = cyc + 1;
      e.v       = vecs[5];
      sb_q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      chk("sh_busy_before_reset", int'(bus.busy), 1);
      #2;
      reset = 1'b1;
      sb_q.delete();
      #1;
      chk_reset_vals("async_reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      d_before = done_total;
      repeat (10) @(negedge clk);
      chk("after_reset_no_done", done_total - d_before, 0);
      chk("after_reset_busy", int'(bus.busy), 0);
    end

    // MEM_WAIT=1 instance: lb with done in cycle 3.
    m1 = 0; d1 = 0; rw1 = 0; sz1 = -1;
    bus1.start = 1'b1;
    bus1.op    = 3'b010;
    e1 = cyc + 1;
    @(negedge clk);
    bus1.start = 1'b0;
    bus1.op    = 3'b111;
    if (bus1.mdr_load) m1 = cyc - e1 + 1;
    for (int k = 0; k < 20; k++) begin
      if (bus1.done) begin
        d1  = cyc - e1 + 1;
        rw1 = int'(bus1.reg_write);
        sz1 = int'(bus1.load_size_ctrl);
        break;
      end
      @(negedge clk);
      if (bus1.mdr_load) m1 = cyc - e1 + 1;
    end
    chk("mw1_done_latency", d1, 3);
    chk("mw1_mdr_cycle", m1, 2);
    chk("mw1_reg_write", rw1, 1);
    chk("mw1_load_size", sz1, 0);
    @(negedge clk);
    chk("mw1_busy_after", int'(bus1.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
